// File: rtl/nrisc_ula_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : nrisc_ula_pkg
//  Description : Shared opcodes and status-flag bit positions for the NRISC
//                arithmetic/logic unit.
//  Revision    : 1.0 - initial release
// ============================================================================
package nrisc_ula_pkg;

    // Operation select codes driven on ULA_ctrl
    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b0001;
    localparam logic [3:0] OP_AND = 4'b0010;
    localparam logic [3:0] OP_OR  = 4'b0011;
    localparam logic [3:0] OP_XOR = 4'b0100;
    localparam logic [3:0] OP_SHR = 4'b0101;
    localparam logic [3:0] OP_SHL = 4'b0110;
    localparam logic [3:0] OP_NOT = 4'b0111;
    localparam logic [3:0] OP_RTR = 4'b1101;
    localparam logic [3:0] OP_RTL = 4'b1110;

    // Bit positions inside the 3-bit status word {minus, zero, carry}
    localparam int FLAG_MINUS = 2;
    localparam int FLAG_ZERO  = 1;
    localparam int FLAG_CARRY = 0;

endpackage
`default_nettype wire

// File: rtl/nrisc_ula_addsub.sv
`default_nettype none
// ============================================================================
//  Module      : nrisc_ula_addsub
//  Description : TAM-bit signed add/subtract. The operation is carried out on
//                a sign-extended TAM+1-bit copy so the true sign of the result
//                is available even when the TAM-bit result wraps.
//  Revision    : 1.0 - initial release
// ============================================================================
module nrisc_ula_addsub #(
    parameter int TAM = 4
) (
    input  logic [TAM-1:0] i_a,
    input  logic [TAM-1:0] i_b,
    input  logic           i_sub,
    output logic [TAM-1:0] o_sum,
    output logic           o_carry,
    output logic           o_minus
);

    logic [TAM:0] w_a_ext;
    logic [TAM:0] w_b_ext;
    logic [TAM:0] w_exact;
    logic         w_msb_cin;

    // Exact sum/difference; the extra bit can never overflow for signed inputs
    always_comb begin
        w_a_ext = {i_a[TAM-1], i_a};
        w_b_ext = {i_b[TAM-1], i_b};
        w_exact = i_sub ? (w_a_ext - w_b_ext) : (w_a_ext + w_b_ext);
    end

    // Carry is the carry into the MSB; for subtraction it is inverted (no
    // borrow) and forced low when nothing is subtracted
    always_comb begin
        o_sum     = w_exact[TAM-1:0];
        o_minus   = w_exact[TAM];
        w_msb_cin = i_a[TAM-1] ^ i_b[TAM-1] ^ w_exact[TAM-1];
        if (i_sub) begin
            o_carry = (|i_b) & ~w_msb_cin;
        end else begin
            o_carry = w_msb_cin;
        end
    end

endmodule
`default_nettype wire

// File: rtl/nrisc_ula.sv
`default_nettype none
// ============================================================================
//  Module      : nrisc_ula
//  Description : NRISC arithmetic/logic unit. Combinational result and
//                {minus, zero, carry} status plus a registered copy of the
//                status for later conditional instructions.
//                Optional: define NRISC_ULA_ROTATE_EN to implement the rotate
//                operations (RTR/RTL); otherwise those codes act as undefined.
//  Revision    : 1.0 - initial release
// ============================================================================
module nrisc_ula
    import nrisc_ula_pkg::*;
#(
    parameter int TAM = 4
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [TAM-1:0] ULA_A,
    input  logic [TAM-1:0] ULA_B,
    input  logic           incdec,
    input  logic [3:0]     ULA_ctrl,
    output logic [TAM-1:0] ULA_OUT,
    output logic [2:0]     ULA_flags,
    output logic [2:0]     ULA_flags_reg
);

    localparam logic [TAM-1:0] c_ONE = {{(TAM-1){1'b0}}, 1'b1};

    logic [TAM-1:0] w_be;
    logic [TAM-1:0] w_as_sum;
    logic           w_as_carry;
    logic           w_as_minus;
    logic [TAM-1:0] w_out;
    logic           w_minus;
    logic           w_carry;
    logic [2:0]     w_flags;
    logic [2:0]     r_flags;

    // Increment/decrement substitutes the constant 1 only for ADD/SUB
    always_comb begin
        if (incdec && ((ULA_ctrl == OP_ADD) || (ULA_ctrl == OP_SUB))) begin
            w_be = c_ONE;
        end else begin
            w_be = ULA_B;
        end
    end

    nrisc_ula_addsub #(
        .TAM (TAM)
    ) u_addsub (
        .i_a     (ULA_A),
        .i_b     (w_be),
        .i_sub   (ULA_ctrl == OP_SUB),
        .o_sum   (w_as_sum),
        .o_carry (w_as_carry),
        .o_minus (w_as_minus)
    );

    // Operation select; anything not listed yields zero with clear minus/carry
    always_comb begin
        w_out   = '0;
        w_minus = 1'b0;
        w_carry = 1'b0;
        case (ULA_ctrl)
            OP_ADD, OP_SUB: begin
                w_out   = w_as_sum;
                w_minus = w_as_minus;
                w_carry = w_as_carry;
            end
            OP_AND: w_out = ULA_A & ULA_B;
            OP_OR:  w_out = ULA_A | ULA_B;
            OP_XOR: w_out = ULA_A ^ ULA_B;
            OP_NOT: w_out = ~ULA_A;
            OP_SHR: begin
                w_out   = {ULA_A[TAM-1], ULA_A[TAM-1:1]};
                w_carry = ULA_A[0];
            end
            OP_SHL: begin
                w_out   = {ULA_A[TAM-2:0], 1'b0};
                w_carry = ULA_A[TAM-1];
            end
`ifdef NRISC_ULA_ROTATE_EN
            OP_RTR: w_out = {ULA_A[0], ULA_A[TAM-1:1]};
            OP_RTL: w_out = {ULA_A[TAM-2:0], ULA_A[TAM-1]};
`endif
            default: begin
                w_out   = '0;
                w_minus = 1'b0;
                w_carry = 1'b0;
            end
        endcase
    end

    // Assemble the status word; zero is derived from the selected result
    always_comb begin
        w_flags             = '0;
        w_flags[FLAG_MINUS] = w_minus;
        w_flags[FLAG_ZERO]  = ~(|w_out);
        w_flags[FLAG_CARRY] = w_carry;
    end

    // Hold last status for conditional instructions; reset wins
    always_ff @(posedge clk) begin
        if (rst) begin
            r_flags <= '0;
        end else begin
            r_flags <= w_flags;
        end
    end

    assign ULA_OUT       = w_out;
    assign ULA_flags     = w_flags;
    assign ULA_flags_reg = r_flags;

endmodule
`default_nettype wire

// File: tb/tb_nrisc_ula.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nrisc_ula
//  Description : Scoreboard bench for nrisc_ula (TAM=4). The driver applies
//                one operation per clock and queues the expected result,
//                status and registered status; a monitor on the falling edge
//                pops and compares.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nrisc_ula;

    localparam int TAM  = 4;
    localparam int FULL = 1 << TAM;
    localparam int HALF = 1 << (TAM - 1);

    logic           clk;
    logic           rst;
    logic [TAM-1:0] ULA_A;
    logic [TAM-1:0] ULA_B;
    logic           incdec;
    logic [3:0]     ULA_ctrl;
    logic [TAM-1:0] ULA_OUT;
    logic [2:0]     ULA_flags;
    logic [2:0]     ULA_flags_reg;

    typedef struct {
        logic [TAM-1:0] out;
        logic [2:0]     flags;
        logic [2:0]     freg;
        string          name;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    logic       prev_rst   = 1'b1;
    logic [2:0] prev_flags = 3'b000;

    nrisc_ula #(
        .TAM (TAM)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .ULA_A         (ULA_A),
        .ULA_B         (ULA_B),
        .incdec        (incdec),
        .ULA_ctrl      (ULA_ctrl),
        .ULA_OUT       (ULA_OUT),
        .ULA_flags     (ULA_flags),
        .ULA_flags_reg (ULA_flags_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: signed integer arithmetic straight from the operation rules.
    // Returns {out, minus, zero, carry}.
    function automatic logic [TAM+2:0] model(input int a, input int b, input bit inc, input int op);
        int  be, sa, sbe, ex, o;
        bit  mn, cy;
        logic [TAM-1:0] ov;
        be = (inc && (op == 0 || op == 1)) ? 1 : b;
        sa  = (a  >= HALF) ? a  - FULL : a;
        sbe = (be >= HALF) ? be - FULL : be;
        mn = 1'b0;
        cy = 1'b0;
        o  = 0;
        case (op)
            0: begin
                ex = sa + sbe;
                o  = ((ex % FULL) + FULL) % FULL;
                mn = (ex < 0);
                cy = ((a % HALF) + (be % HALF)) >= HALF;
            end
            1: begin
                ex = sa - sbe;
                o  = ((ex % FULL) + FULL) % FULL;
                mn = (ex < 0);
                cy = (be != 0) && ((a % HALF) >= (be % HALF));
            end
            2: o = a & b;
            3: o = a | b;
            4: o = a ^ b;
            7: o = (FULL - 1) - a;
            5: begin
                o  = (a / 2) + ((a >= HALF) ? HALF : 0);
                cy = (a % 2) == 1;
            end
            6: begin
                o  = (a * 2) % FULL;
                cy = (a >= HALF);
            end
`ifdef NRISC_ULA_ROTATE_EN
            13: o = (a / 2) + (a % 2) * HALF;
            14: o = ((a * 2) % FULL) + (a / HALF);
`endif
            default: o = 0;
        endcase
        ov = o[TAM-1:0];
        return {ov, mn, (o == 0), cy};
    endfunction

    // Apply one operation just after a rising edge and queue what must be seen
    task automatic apply(input logic [TAM-1:0] a, input logic [TAM-1:0] b, input logic inc,
                         input logic [3:0] op, input logic rst_v,
                         input logic [TAM-1:0] eo, input logic [2:0] ef, input string nm);
        exp_t e;
        @(posedge clk);
        #1;
        ULA_A    = a;
        ULA_B    = b;
        incdec   = inc;
        ULA_ctrl = op;
        rst      = rst_v;
        e.out   = eo;
        e.flags = ef;
        e.freg  = prev_rst ? 3'b000 : prev_flags;
        e.name  = nm;
        q.push_back(e);
        prev_rst   = rst_v;
        prev_flags = ef;
    endtask

    task automatic apply_rand(input logic rst_v);
        logic [TAM-1:0] a, b;
        logic           inc;
        logic [3:0]     op;
        logic [TAM+2:0] m;
        a   = TAM'($urandom_range(0, FULL - 1));
        b   = TAM'($urandom_range(0, FULL - 1));
        inc = 1'($urandom_range(0, 1));
        op  = 4'($urandom_range(0, 15));
        m   = model(int'(a), int'(b), inc, int'(op));
        apply(a, b, inc, op, rst_v, m[TAM+2:3], m[2:0], "rand");
    endtask

    // Monitor: compare every queued expectation on the falling edge
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (ULA_OUT !== e.out) begin
                    errors++;
                    $display("FAIL %s out: got %b expected %b (A=%b B=%b inc=%b ctrl=%b)",
                             e.name, ULA_OUT, e.out, ULA_A, ULA_B, incdec, ULA_ctrl);
                end
                checks++;
                if (ULA_flags !== e.flags) begin
                    errors++;
                    $display("FAIL %s flags: got %b expected %b (A=%b B=%b inc=%b ctrl=%b)",
                             e.name, ULA_flags, e.flags, ULA_A, ULA_B, incdec, ULA_ctrl);
                end
                checks++;
                if (ULA_flags_reg !== e.freg) begin
                    errors++;
                    $display("FAIL %s flags_reg: got %b expected %b", e.name, ULA_flags_reg, e.freg);
                end
            end
        end
    end

    // Driver: directed vectors first, then randomized traffic with sporadic reset
    initial begin
        rst      = 1'b1;
        ULA_A    = '0;
        ULA_B    = '0;
        incdec   = 1'b0;
        ULA_ctrl = 4'b0000;

        apply(4'b0111, 4'b0001, 1'b0, 4'b0000, 1'b1, 4'b1000, 3'b001, "reset_add");
        apply(4'b0111, 4'b0001, 1'b0, 4'b0000, 1'b0, 4'b1000, 3'b001, "add_0111_0001");
        apply(4'b0011, 4'b0101, 1'b0, 4'b0001, 1'b0, 4'b1110, 3'b100, "sub_0011_0101");
        apply(4'b0000, 4'b0000, 1'b0, 4'b0001, 1'b0, 4'b0000, 3'b010, "sub_zero");
        apply(4'b1111, 4'b0110, 1'b1, 4'b0000, 1'b0, 4'b0000, 3'b011, "inc_1111");
        apply(4'b0000, 4'b0110, 1'b1, 4'b0001, 1'b0, 4'b1111, 3'b100, "dec_0000");
        apply(4'b1001, 4'b0000, 1'b0, 4'b0101, 1'b0, 4'b1100, 3'b001, "shr_1001");
        apply(4'b1001, 4'b0000, 1'b0, 4'b0110, 1'b1, 4'b0010, 3'b001, "shl_1001_rst");
        apply(4'b1111, 4'b0000, 1'b0, 4'b0111, 1'b0, 4'b0000, 3'b010, "not_1111");
        apply(4'b1100, 4'b1010, 1'b1, 4'b0010, 1'b0, 4'b1000, 3'b000, "and_incdec_ignored");
        apply(4'b1100, 4'b1010, 1'b0, 4'b0100, 1'b0, 4'b0110, 3'b000, "xor");
`ifdef NRISC_ULA_ROTATE_EN
        apply(4'b1001, 4'b0000, 1'b0, 4'b1101, 1'b0, 4'b1100, 3'b000, "rtr_1001");
        apply(4'b1001, 4'b0000, 1'b0, 4'b1110, 1'b0, 4'b0011, 3'b000, "rtl_1001");
`else
        apply(4'b1001, 4'b0000, 1'b0, 4'b1101, 1'b0, 4'b0000, 3'b010, "rtr_disabled");
        apply(4'b1001, 4'b0000, 1'b0, 4'b1110, 1'b0, 4'b0000, 3'b010, "rtl_disabled");
`endif
        apply(4'b0111, 4'b0111, 1'b0, 4'b1111, 1'b0, 4'b0000, 3'b010, "undef_1111");
        apply(4'b0111, 4'b0001, 1'b0, 4'b0000, 1'b0, 4'b1000, 3'b001, "add_before_idle");

        for (int i = 0; i < 400; i++) begin
            apply_rand(($urandom_range(0, 15) == 0) ? 1'b1 : 1'b0);
        end

        // Drain: the monitor must consume everything within a bounded time
        for (int i = 0; i < 20 && q.size() != 0; i++) begin
            @(posedge clk);
        end
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, required 0", q.size());
        end
        @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
